// File: rtl/cga_intr_sync.sv
// Interrupt/error input conditioning: 2-flop synchronizers, glitch filters on bus interrupt
// lines, sticky error flags with strobe clear. Optional parity event counter: CGA_INTR_SYNC_EVCNT_EN.
module cga_intr_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic       MCLK,
  input  logic       RESETN,
  input  logic       BINT10N,
  input  logic       BINT11N,
  input  logic       BINT12N,
  input  logic       BINT13N,
  input  logic       BINT15N,
  input  logic       POWFAILIN_N,
  input  logic       PARERRIN_N,
  input  logic       IOXERRIN_N,
  input  logic       CLRSTB,
  input  logic [2:0] CLRSEL,
  output logic       BINT10N_O,
  output logic       BINT11N_O,
  output logic       BINT12N_O,
  output logic       BINT13N_O,
  output logic       BINT15N_O,
  output logic       POWFAILN,
  output logic       PARERRN,
  output logic       IOXERRN,
  output logic       CLRACK,
  output logic       ANYN,
  output logic [7:0] PARCNT
);

  localparam logic [2:0] FILT_LAST = 3'(FILT_LEN - 1);

  // Error vectors are ordered to match CLRSEL: [0] power-fail, [1] parity, [2] IO error.
  logic [4:0] bint_in, bint_sync_p0, bint_sync_p1, bint_out;
  logic [2:0] err_in, err_sync_p0, err_sync_p1, err_hist_p2, err_flag;
  logic [2:0] err_fall, err_clr;
  logic [2:0] filt_cnt [5];
  logic       clr_ack;

  assign bint_in = {BINT15N, BINT13N, BINT12N, BINT11N, BINT10N};
  assign err_in  = {IOXERRIN_N, PARERRIN_N, POWFAILIN_N};

  // Stage p0/p1: two-flop synchronizers
  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      bint_sync_p0 <= '1;
      bint_sync_p1 <= '1;
      err_sync_p0  <= '1;
      err_sync_p1  <= '1;
    end else begin
      bint_sync_p0 <= bint_in;
      bint_sync_p1 <= bint_sync_p0;
      err_sync_p0  <= err_in;
      err_sync_p1  <= err_sync_p0;
    end
  end

  // Stage p2: level filters; output follows only after FILT_LEN consecutive differing samples
  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      bint_out <= '1;
      for (int i = 0; i < 5; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (bint_sync_p1[i] == bint_out[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          bint_out[i] <= bint_sync_p1[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 3'd1;
        end
      end
    end
  end

  // A still-active power-fail source blocks its own clear.
  assign err_fall = err_hist_p2 & ~err_sync_p1;
  assign err_clr  = (CLRSTB ? CLRSEL : 3'b000) & {2'b11, err_sync_p1[0]};

  // Stage p2: edge history, sticky flags (set beats clear), clear acknowledge
  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      err_hist_p2 <= '1;
      err_flag    <= '1;
      clr_ack     <= 1'b0;
    end else begin
      err_hist_p2 <= err_sync_p1;
      clr_ack     <= CLRSTB;
      for (int i = 0; i < 3; i++) begin
        if (err_fall[i])     err_flag[i] <= 1'b0;
        else if (err_clr[i]) err_flag[i] <= 1'b1;
      end
    end
  end

`ifdef CGA_INTR_SYNC_EVCNT_EN
  logic [7:0] par_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN)          par_cnt <= '0;
    else if (err_fall[1]) par_cnt <= sat_inc(par_cnt);
  end

  assign PARCNT = par_cnt;
`else
  assign PARCNT = 8'd0;
`endif

  assign {BINT15N_O, BINT13N_O, BINT12N_O, BINT11N_O, BINT10N_O} = bint_out;
  assign {IOXERRN, PARERRN, POWFAILN} = err_flag;
  assign CLRACK = clr_ack;
  assign ANYN   = &{bint_out, err_flag};

endmodule

// File: tb/tb_cga_intr_sync.sv
// Directed self-checking bench for cga_intr_sync (FILT_LEN=3).
module tb_cga_intr_sync;

  logic       MCLK, RESETN;
  logic       BINT10N, BINT11N, BINT12N, BINT13N, BINT15N;
  logic       POWFAILIN_N, PARERRIN_N, IOXERRIN_N;
  logic       CLRSTB;
  logic [2:0] CLRSEL;
  logic       BINT10N_O, BINT11N_O, BINT12N_O, BINT13N_O, BINT15N_O;
  logic       POWFAILN, PARERRN, IOXERRN, CLRACK, ANYN;
  logic [7:0] PARCNT;

  int n_chk  = 0;
  int n_fail = 0;

  cga_intr_sync #(.FILT_LEN(3)) dut (
    .MCLK(MCLK), .RESETN(RESETN),
    .BINT10N(BINT10N), .BINT11N(BINT11N), .BINT12N(BINT12N),
    .BINT13N(BINT13N), .BINT15N(BINT15N),
    .POWFAILIN_N(POWFAILIN_N), .PARERRIN_N(PARERRIN_N), .IOXERRIN_N(IOXERRIN_N),
    .CLRSTB(CLRSTB), .CLRSEL(CLRSEL),
    .BINT10N_O(BINT10N_O), .BINT11N_O(BINT11N_O), .BINT12N_O(BINT12N_O),
    .BINT13N_O(BINT13N_O), .BINT15N_O(BINT15N_O),
    .POWFAILN(POWFAILN), .PARERRN(PARERRN), .IOXERRN(IOXERRN),
    .CLRACK(CLRACK), .ANYN(ANYN), .PARCNT(PARCNT)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  initial begin
    RESETN = 1'b0;
    {BINT10N, BINT11N, BINT12N, BINT13N, BINT15N} = 5'h1F;
    POWFAILIN_N = 1'b0; PARERRIN_N = 1'b1; IOXERRIN_N = 1'b1;
    CLRSTB = 1'b0; CLRSEL = 3'b000;

    // Power-fail held low through reset
    tick(3);
    chk("rst_outs", {BINT15N_O, BINT13N_O, BINT12N_O, BINT11N_O, BINT10N_O,
                     POWFAILN, PARERRN, IOXERRN}, 8'hFF);
    chk("rst_anyn", 8'(ANYN), 8'd1);
    chk("rst_ack", 8'(CLRACK), 8'd0);
    chk("rst_parcnt", PARCNT, 8'd0);
    RESETN = 1'b1;
    tick(2);
    chk("pf_rel_e2", 8'(POWFAILN), 8'd1);
    tick(1);
    chk("pf_rel_e3", 8'(POWFAILN), 8'd0);
    chk("pf_anyn", 8'(ANYN), 8'd0);

    // Clear ignored while source still low, honoured once released
    CLRSTB = 1'b1; CLRSEL = 3'b001;
    tick(1);
    chk("pf_held", 8'(POWFAILN), 8'd0);
    chk("pf_held_ack", 8'(CLRACK), 8'd1);
    CLRSTB = 1'b0; CLRSEL = 3'b000; POWFAILIN_N = 1'b1;
    tick(1);
    chk("pf_ack_drop", 8'(CLRACK), 8'd0);
    tick(2);
    CLRSTB = 1'b1; CLRSEL = 3'b001;
    tick(1);
    chk("pf_clr", 8'(POWFAILN), 8'd1);
    chk("pf_clr_anyn", 8'(ANYN), 8'd1);
    CLRSTB = 1'b0; CLRSEL = 3'b000;
    tick(2);

    // Filter latency and glitch rejection
    BINT12N = 1'b0;
    tick(4);
    chk("filt_e4", 8'(BINT12N_O), 8'd1);
    tick(1);
    chk("filt_e5", 8'(BINT12N_O), 8'd0);
    chk("filt_anyn", 8'(ANYN), 8'd0);
    BINT12N = 1'b1;
    tick(5);
    chk("filt_rel", 8'(BINT12N_O), 8'd1);
    BINT12N = 1'b0;
    tick(2);
    BINT12N = 1'b1;
    tick(6);
    chk("filt_glitch", 8'(BINT12N_O), 8'd1);
    chk("filt_glitch_anyn", 8'(ANYN), 8'd1);

    // Parity flag set and clear at edge 10
    PARERRIN_N = 1'b0;
    tick(2);
    chk("par_e2", 8'(PARERRN), 8'd1);
    tick(1);
    chk("par_e3", 8'(PARERRN), 8'd0);
    chk("par_anyn", 8'(ANYN), 8'd0);
    tick(6);
    CLRSTB = 1'b1; CLRSEL = 3'b010;
    tick(1);
    chk("par_clr", 8'(PARERRN), 8'd1);
    chk("par_ack", 8'(CLRACK), 8'd1);
    CLRSTB = 1'b0; CLRSEL = 3'b000;
    tick(1);
    chk("par_ack_drop", 8'(CLRACK), 8'd0);
    PARERRIN_N = 1'b1;
    tick(3);

    // Set coincides with clear, then back-to-back strobes
    IOXERRIN_N = 1'b0;
    tick(2);
    CLRSTB = 1'b1; CLRSEL = 3'b100;
    tick(1);
    chk("iox_set_wins", 8'(IOXERRN), 8'd0);
    chk("iox_ack", 8'(CLRACK), 8'd1);
    tick(1);
    chk("iox_clr", 8'(IOXERRN), 8'd1);
    chk("b2b_ack", 8'(CLRACK), 8'd1);
    CLRSEL = 3'b000;
    tick(1);
    chk("sel0_ack", 8'(CLRACK), 8'd1);
    CLRSTB = 1'b0;
    tick(1);
    chk("ack_end", 8'(CLRACK), 8'd0);
    IOXERRIN_N = 1'b1;
    tick(3);

    // Reset mid-filter and mid-clear
    BINT10N = 1'b0; CLRSTB = 1'b1;
    tick(4);
    CLRSTB = 1'b0;
    chk("mid_ack", 8'(CLRACK), 8'd1);
    RESETN = 1'b0;
    #1;
    chk("mid_rst_ack", 8'(CLRACK), 8'd0);
    tick(1);
    RESETN = 1'b1;
    tick(4);
    chk("mid_filt_e4", 8'(BINT10N_O), 8'd1);
    tick(1);
    chk("mid_filt_e5", 8'(BINT10N_O), 8'd0);
    BINT10N = 1'b1;
    tick(5);

    // Parity event counter
    for (int i = 0; i < 300; i++) begin
      PARERRIN_N = 1'b0;
      tick(2);
      PARERRIN_N = 1'b1;
      tick(2);
    end
    tick(3);
`ifdef CGA_INTR_SYNC_EVCNT_EN
    chk("parcnt_sat", PARCNT, 8'd255);
`else
    chk("parcnt_off", PARCNT, 8'd0);
`endif
    chk("parcnt_flag", 8'(PARERRN), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cga_intr_sync.md
CGA_INTR_SYNC -- requirements
Module: cga_intr_sync

Interface
REQ-001 SHALL have parameter FILT_LEN, default 3, legal range 1..7: consecutive synchronized samples required before a level-line output changes.
REQ-002 SHALL have port MCLK  input  1  master clock; all flops sample on its rising edge.
REQ-003 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports BINT10N, BINT11N, BINT12N, BINT13N, BINT15N  input  1 each  asynchronous bus interrupt lines, active-low.
REQ-005 SHALL have ports POWFAILIN_N, PARERRIN_N, IOXERRIN_N  input  1 each  asynchronous error sources, active-low.
REQ-006 SHALL have port CLRSTB  input  1  clear strobe, one MCLK cycle.
REQ-007 SHALL have port CLRSEL  input  3  one-hot clear select: [0] power-fail, [1] parity, [2] IO error.
REQ-008 SHALL have ports BINT10N_O, BINT11N_O, BINT12N_O, BINT13N_O, BINT15N_O  output  1 each  filtered bus interrupts, active-low.
REQ-009 SHALL have ports POWFAILN, PARERRN, IOXERRN  output  1 each  sticky error flags, active-low; these feed the interrupt source logic.
REQ-010 SHALL have port CLRACK  output  1  clear acknowledge, one-cycle pulse.
REQ-011 SHALL have port ANYN  output  1  low when any output of REQ-008/REQ-009 is low.
REQ-012 SHALL have port PARCNT  output  8  parity-event count.

Function
REQ-013 SHALL pass every asynchronous input through a 2-flop synchronizer; stage 2 is the "synced" value.
REQ-014 SHALL give each level line a 3-bit filter counter: synced value equal to output -> counter cleared to 0; different -> counter incremented; on the edge where it is the FILT_LEN-th consecutive differing sample, output takes the synced value and counter clears.
REQ-015 SHALL produce level-line latency as follows: input changes before edge 1 -> output changes at edge 2+FILT_LEN; any pulse shorter than FILT_LEN synced samples never reaches the output.
REQ-016 SHALL keep a one-flop history of each synced error source and detect falling edges (history 1, synced 0).
REQ-017 SHALL set the corresponding sticky flag (output low) on the edge following detection: input falls before edge 1 -> flag low at edge 3.
REQ-018 SHALL clear, on an edge with CLRSTB=1, every flag whose CLRSEL bit is 1, and SHALL drive CLRACK=1 for the following cycle; CLRSEL=000 with CLRSTB=1 still acks.
REQ-019 SHALL let set win when set and clear coincide on the same flag; flag stays low and CLRACK still pulses.
REQ-020 SHALL ignore clear of the power-fail flag while synced POWFAILIN_N is 0.
REQ-021 SHALL acknowledge back-to-back strobes individually: one CLRACK pulse per CLRSTB cycle.
REQ-022 SHALL make ANYN purely combinational from registered outputs; all other outputs SHALL be registered.

Reset
REQ-023 SHALL while RESETN=0 force synchronizers and histories to 1, filter counters to 0, all active-low outputs and ANYN to 1, CLRACK to 0, PARCNT to 0.
REQ-024 SHALL treat a source held low through reset release as a falling edge: flag low at edge 3 after release.
REQ-025 SHALL, on reset asserted mid-filter or mid-clear, discard the partial count and any pending CLRACK.

Configuration
REQ-026 SHALL, with macro CGA_INTR_SYNC_EVCNT_EN defined, increment PARCNT by 1 on every parity falling-edge detection, saturating at 255, cleared only by reset.
REQ-027 SHALL, without CGA_INTR_SYNC_EVCNT_EN, tie PARCNT to 0 and instantiate no counter.

Verification
REQ-028 SHALL cover: FILT_LEN=3, BINT12N 1->0 before edge 1 -> BINT12N_O low at edge 5; a 2-cycle low glitch -> BINT12N_O stays high.
REQ-029 SHALL cover: PARERRIN_N falls before edge 1 -> PARERRN low at edge 3, ANYN low; CLRSTB with CLRSEL=010 at edge 10 -> PARERRN high and CLRACK high after edge 10 for one cycle.
REQ-030 SHALL cover: new IOXERRIN_N falling-edge detection on the same edge as CLRSTB with CLRSEL=100 -> IOXERRN stays low, CLRACK pulses.
REQ-031 SHALL cover: POWFAILIN_N held low, clear power-fail -> POWFAILN stays low; release input, clear again -> POWFAILN high.
REQ-032 SHALL cover: macro defined, 300 parity pulses -> PARCNT=255; macro undefined -> PARCNT=0.
REQ-033 SHALL cover: POWFAILIN_N low during reset -> all outputs high during reset, POWFAILN low at edge 3 after release.
